dma_sequencer_2940: RTL
=======================

// Module: dma_sequencer_2940
// PURPOSE
//  Sequences one AM2940 DMA address generator through a complete block transfer.
//  - Configuration: writes the control register, loads the address and loads the word count.
//  - Transfer: performs one counter step per requester beat (dreq/dack) and watches Done.
//  - Finish: reports completion, or re-arms through Reinitialize Counters when auto-reinit is set.
//  Sits between the host/config logic and the AM2940 Instruction/DataInput/ACI/WCI pins.
// PARAMETERS
//  DW    8    width of address, word count and data_out
//  WDOG  255  max consecutive ARMED cycles without dreq before error (0 = watchdog off)
// PORTS
//  clk        in   1   rising-edge clock, shared with the AM2940
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   one-cycle request; accepted only in IDLE
//  abort      in   1   cancel the transfer in progress
//  cfg_mode   in   3   control-register value (bits[1:0] = AM2940 done mode)
//  cfg_auto   in   1   auto-reinit after completion (sampled at start)
//  cfg_addr   in   DW  start address
//  cfg_count  in   DW  word count
//  dreq       in   1   requester beat request (level)
//  done       in   1   AM2940 Done output
//  instr      out  3   AM2940 Instruction
//  data_out   out  DW  AM2940 DataInput
//  cnt_en_n   out  1   drives both ACI and WCI; active-low count enable
//  dack       out  1   beat acknowledge
//  busy       out  1   high in every state except IDLE
//  xfer_done  out  1   one-cycle pulse at completion
//  err        out  1   sticky watchdog error; cleared by the next accepted start
//  beats      out  DW  beats issued since start, wraps modulo 2^DW
// BEHAVIOUR
//  Instruction codes:
//   000 WrCR, 100 Reinit, 101 LdAddr, 110 LdWC, 111 Enable, 011 RdAC (idle/hold code).
//  Reset values: state=IDLE, instr=011, data_out=0, cnt_en_n=1, dack=0, busy=0,
//   xfer_done=0, err=0, beats=0.
//  All outputs are registered; each state drives its outputs for exactly the cycles it is occupied.
//  Start capture: on accepted start, cfg_* are latched, beats<=0 and err<=0.
//  States and transitions:
//   IDLE:  instr=011. start & !abort -> WR_CR.
//   WR_CR: instr=000, data_out={0,mode}. -> LD_ADDR.
//   LD_ADDR: instr=101, data_out=addr. -> LD_WC.
//   LD_WC: instr=110, data_out=count. -> ARMED.
//   ARMED: instr=011, cnt_en_n=1; the watchdog counts cycles here.
//    - dreq -> BEAT; the watchdog clears.
//    - watchdog reaches WDOG -> IDLE, err<=1, no xfer_done.
//   BEAT (one cycle): instr=111, cnt_en_n=0, dack=1, beats<=beats+1. -> CHECK.
//   CHECK (one cycle): instr=111, cnt_en_n=1; done is sampled here (post-step value).
//    - done=1 -> FINISH.
//    - done=0 -> ARMED.
//   FINISH (one cycle): xfer_done=1, instr=011.
//    - auto=1 -> REINIT.
//    - auto=0 -> IDLE.
//   REINIT (one cycle): instr=100, beats<=0. -> ARMED.
//  Beat timing:
//   - Minimum beat spacing is 3 cycles (ARMED->BEAT->CHECK).
//   - dack is asserted exactly once per beat, even when dreq stays high.
//  abort:
//   - Any non-IDLE state -> IDLE on the next edge, instr=011, cnt_en_n=1.
//   - No xfer_done pulse; err is unchanged.
//   - abort beats start in IDLE and beats done in CHECK.
//  start while busy: ignored; no state or config change.
//  Asynchronous reset mid-transfer: immediate return to the reset values; the AM2940 contents are undefined.
//  The beats counter wraps FF->00 with no flag.
// TESTING
//  1. Config sequence: reset; start with mode=011, addr=88, count=04.
//     -> instr 000/101/110 on consecutive cycles, data_out 03/88/04, then 011 with busy=1.
//  2. Four beats: dreq held high, done asserted after the 4th step.
//     -> 4 dack pulses 3 cycles apart, beats=4, one xfer_done, then IDLE with busy=0.
//  3. Auto-reinit: as scenario 2 with cfg_auto=1.
//     -> xfer_done, then instr=100 for one cycle, beats=0, back to ARMED.
//  4. Abort during BEAT with done=1 in the following cycle.
//     -> IDLE, no xfer_done, cnt_en_n=1.
//  5. WDOG=10 with no dreq.
//     -> err=1 after 10 ARMED cycles, then IDLE; the next start clears err.
//  6. Start pulsed while busy, and start+abort together in IDLE.
//     -> both ignored; cfg registers and state unchanged.

Source files
------------

// File: rtl/dma_sequencer_2940.sv
// Sequencer that walks one AM2940 DMA address generator through a block
// transfer: configuration (control register, address, word count), one
// counter step per requester beat, and completion or auto re-arm.
//
// Handshake: a beat is requested by holding dreq high while the sequencer
// is ARMED. The sequencer answers with exactly one single-cycle dack per beat
// and will not look at dreq again until the post-step CHECK cycle has passed.
// A level dreq that stays high therefore yields one beat every three cycles.
//
// Every output is registered and decoded from the next state. As a result, the
// pins always show the values of the state the FSM is in during that cycle.
module dma_sequencer_2940 #(
  parameter int DW   = 8,
  parameter int WDOG = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    cfg_mode,
  input  logic          cfg_auto,
  input  logic [DW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_count,
  input  logic          dreq,
  input  logic          done,
  output logic [2:0]    instr,
  output logic [DW-1:0] data_out,
  output logic          cnt_en_n,
  output logic          dack,
  output logic          busy,
  output logic          xfer_done,
  output logic          err,
  output logic [DW-1:0] beats,
  output logic [3:0]    dbgState
);

  typedef enum logic [3:0] {
    sIdle, sWrCr, sLdAddr, sLdWc, sArmed, sBeat, sCheck, sFinish, sReinit
  } stateT;

  localparam logic [2:0] iWrCr   = 3'b000;
  localparam logic [2:0] iReinit = 3'b100;
  localparam logic [2:0] iLdAddr = 3'b101;
  localparam logic [2:0] iLdWc   = 3'b110;
  localparam logic [2:0] iEnable = 3'b111;
  localparam logic [2:0] iHold   = 3'b011;

  // Watchdog holds ARMED cycles already spent; it trips on the WDOG-th one.
  localparam int WdW = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [WdW-1:0] wdLimit = WdW'(WDOG - 1);

  stateT          state, stateNext;
  logic [DW-1:0]  addrQ, countQ;
  logic           autoQ;
  logic [WdW-1:0] wdCnt;
  logic           wdExpired, acceptStart, wdTrip;

  logic [2:0]     instrNext;
  logic [DW-1:0]  dataNext;
  logic           cntEnNNext, dackNext, busyNext, xdoneNext;

  assign wdExpired = (WDOG != 0) && (wdCnt == wdLimit);
  assign dbgState  = state;

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    stateNext   = state;
    acceptStart = 1'b0;
    wdTrip      = 1'b0;
    case (state)
      sIdle: begin
        if (start && !abort) begin
          stateNext   = sWrCr;
          acceptStart = 1'b1;
        end
      end
      sWrCr:   stateNext = sLdAddr;
      sLdAddr: stateNext = sLdWc;
      sLdWc:   stateNext = sArmed;
      sArmed: begin
        if (dreq) begin
          stateNext = sBeat;
        end else if (wdExpired) begin
          stateNext = sIdle;
          wdTrip    = !abort;
        end
      end
      sBeat:   stateNext = sCheck;
      sCheck:  stateNext = done ? sFinish : sArmed;
      sFinish: stateNext = autoQ ? sReinit : sIdle;
      sReinit: stateNext = sArmed;
      default: stateNext = sIdle;
    endcase
    if (abort && state != sIdle) begin
      stateNext = sIdle;
    end
  end

  // Output decode for the state about to be entered.
  always_comb begin
    instrNext  = iHold;
    dataNext   = '0;
    cntEnNNext = 1'b1;
    dackNext   = 1'b0;
    busyNext   = (stateNext != sIdle);
    xdoneNext  = 1'b0;
    case (stateNext)
      sWrCr: begin
        instrNext = iWrCr;
        dataNext  = DW'(cfg_mode);
      end
      sLdAddr: begin
        instrNext = iLdAddr;
        dataNext  = addrQ;
      end
      sLdWc: begin
        instrNext = iLdWc;
        dataNext  = countQ;
      end
      sBeat: begin
        instrNext  = iEnable;
        cntEnNNext = 1'b0;
        dackNext   = 1'b1;
      end
      sCheck:  instrNext = iEnable;
      sFinish: xdoneNext = 1'b1;
      sReinit: instrNext = iReinit;
      default: instrNext = iHold;
    endcase
  end

  // State register, configuration capture and ARMED watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= sIdle;
      addrQ  <= '0;
      countQ <= '0;
      autoQ  <= 1'b0;
      wdCnt  <= '0;
    end else begin
      state <= stateNext;
      if (acceptStart) begin
        addrQ  <= cfg_addr;
        countQ <= cfg_count;
        autoQ  <= cfg_auto;
      end
      if (state == sArmed && stateNext == sArmed) begin
        wdCnt <= wdCnt + WdW'(1);
      end else begin
        wdCnt <= '0;
      end
    end
  end

  // Registered pin outputs, beat counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr     <= iHold;
      data_out  <= '0;
      cnt_en_n  <= 1'b1;
      dack      <= 1'b0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      err       <= 1'b0;
      beats     <= '0;
    end else begin
      instr     <= instrNext;
      data_out  <= dataNext;
      cnt_en_n  <= cntEnNNext;
      dack      <= dackNext;
      busy      <= busyNext;
      xfer_done <= xdoneNext;
      if (acceptStart) begin
        err <= 1'b0;
      end else if (wdTrip) begin
        err <= 1'b1;
      end
      if (acceptStart || stateNext == sReinit) begin
        beats <= '0;
      end else if (stateNext == sBeat) begin
        beats <= beats + DW'(1);
      end
    end
  end

endmodule
